anubis_round_sequencer: RTL and testbench

Sequencing stage directly upstream of the Anubis `round` datapath. It accepts one 128-bit plaintext block through a start/ready handshake and fetches round keys from the key-schedule RAM. It applies the initial key addition, then drives `round` through every round. Each round it feeds the previous `round_cipher_text` back as the next `plain_text`, and it returns the final ciphertext through a valid/ack handshake.

---
 rtl/anubis_pkg.sv | 19 +
 rtl/anubis_round_timer.sv | 29 ++
 rtl/anubis_round_sequencer.sv | 129 ++++++++++++
 tb/tb_anubis_round_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/anubis_pkg.sv
// Shared definitions for the Anubis round sequencing logic: block/key-index
// widths, the default round count and the sequencer FSM state type.
package anubis_pkg;

  localparam int BLOCK_W            = 128;
  localparam int KEY_IDX_W          = 4;
  localparam int NUM_ROUNDS_DEFAULT = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY0,
    S_WHITEN,
    S_FETCH,
    S_LOAD,
    S_RUN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/anubis_round_timer.sv
// Saturating cycle counter with synchronous clear and a terminal-count flag.
// Shared between the round sequencer and the key-schedule sequencer.
module anubis_round_timer #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_V)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LIMIT_V);

endmodule

// File: rtl/anubis_round_sequencer.sv
// Drives the Anubis round datapath: key whitening, per-round key fetch and
// load, feedback of each round result, and ciphertext hand-off.
module anubis_round_sequencer
  import anubis_pkg::*;
#(
  parameter int NUM_ROUNDS   = NUM_ROUNDS_DEFAULT,
  parameter int ROUND_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ready,
  input  logic [BLOCK_W-1:0]   plain_text_in,
  output logic [BLOCK_W-1:0]   cipher_out,
  output logic                 cipher_valid,
  input  logic                 cipher_ack,
  output logic                 key_rd,
  output logic [KEY_IDX_W-1:0] key_addr,
  input  logic [BLOCK_W-1:0]   key_data,
  output logic                 load_text,
  output logic [KEY_IDX_W-1:0] round_number,
  output logic [KEY_IDX_W-1:0] counter,
  output logic [BLOCK_W-1:0]   round_plain_text,
  output logic [BLOCK_W-1:0]   round_key,
  input  logic [BLOCK_W-1:0]   round_cipher_text
);

  localparam logic [KEY_IDX_W-1:0] LAST_ROUND = KEY_IDX_W'(NUM_ROUNDS);

  seq_state_t             cur, nxt;
  logic [BLOCK_W-1:0]     text_q;
  logic [BLOCK_W-1:0]     key_hold;
  logic [KEY_IDX_W-1:0]   r_q;
  logic                   round_done;
  logic                   timer_clear;
  logic                   timer_en;

  // The counter reads 0 in the load-pulse cycle, so it reaches ROUND_CYCLES
  // exactly ROUND_CYCLES cycles after load_text.
  assign timer_clear = (cur == S_FETCH);
  assign timer_en    = (cur == S_LOAD) || (cur == S_RUN);

  anubis_round_timer #(
    .WIDTH (KEY_IDX_W),
    .LIMIT (ROUND_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .count  (counter),
    .done   (round_done)
  );

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   if (start) nxt = S_KEY0;
      S_KEY0:   nxt = S_WHITEN;
      S_WHITEN: nxt = S_FETCH;
      S_FETCH:  nxt = S_LOAD;
      S_LOAD:   nxt = S_RUN;
      S_RUN:    if (round_done) nxt = (r_q == LAST_ROUND) ? S_DONE : S_FETCH;
      S_DONE:   if (cipher_ack) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    key_rd   = 1'b0;
    key_addr = '0;
    if (cur == S_KEY0) begin
      key_rd = 1'b1;
    end else if (cur == S_FETCH) begin
      key_rd   = 1'b1;
      key_addr = r_q;
    end
  end

  // Key RAM data only exists during LOAD; pass it straight through then so the
  // key is already present alongside the load pulse, and hold it afterwards.
  assign round_key = (cur == S_LOAD) ? key_data : key_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur              <= S_IDLE;
      ready            <= 1'b1;
      cipher_valid     <= 1'b0;
      load_text        <= 1'b0;
      cipher_out       <= '0;
      round_number     <= '0;
      round_plain_text <= '0;
      key_hold         <= '0;
      text_q           <= '0;
      r_q              <= '0;
    end else begin
      cur          <= nxt;
      ready        <= (nxt == S_IDLE);
      cipher_valid <= (nxt == S_DONE);
      load_text    <= (cur == S_FETCH);
      case (cur)
        S_IDLE: begin
          if (start) begin
            text_q <= plain_text_in;
            r_q    <= KEY_IDX_W'(1);
          end
        end
        S_WHITEN: text_q <= text_q ^ key_data;
        S_FETCH: begin
          round_plain_text <= text_q;
          round_number     <= r_q;
        end
        S_LOAD: key_hold <= key_data;
        S_RUN: begin
          if (round_done) begin
            text_q <= round_cipher_text;
            if (r_q == LAST_ROUND) begin
              cipher_out <= round_cipher_text;
            end else begin
              r_q <= r_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_anubis_round_sequencer.sv
// Bench for anubis_round_sequencer: table vectors, hand-written corner cases and
// randomized keys/plaintexts against an XOR-fold reference of the stubbed round.
module tb_anubis_round_sequencer;

  localparam int NR    = 12;
  localparam int RC    = 4;
  localparam int LAT   = 2 + NR * (RC + 2);
  localparam int S_NR  = 1;
  localparam int S_RC  = 1;
  localparam int S_LAT = 2 + S_NR * (S_RC + 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, cipher_ack, ready, cipher_valid, key_rd, load_text;
  logic [127:0] plain_text_in, cipher_out, key_data, round_plain_text, round_key, round_cipher_text;
  logic [3:0]   key_addr, round_number, counter;

  logic         s_start, s_cipher_ack, s_ready, s_cipher_valid, s_key_rd, s_load_text;
  logic [127:0] s_plain_text_in, s_cipher_out, s_key_data, s_round_plain_text, s_round_key, s_round_cipher_text;
  logic [3:0]   s_key_addr, s_round_number, s_counter;

  logic [127:0] key_mem   [0:15];
  logic [127:0] s_key_mem [0:15];

  anubis_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .plain_text_in(plain_text_in),
    .cipher_out(cipher_out), .cipher_valid(cipher_valid), .cipher_ack(cipher_ack),
    .key_rd(key_rd), .key_addr(key_addr), .key_data(key_data), .load_text(load_text),
    .round_number(round_number), .counter(counter), .round_plain_text(round_plain_text),
    .round_key(round_key), .round_cipher_text(round_cipher_text)
  );

  anubis_round_sequencer #(.NUM_ROUNDS(S_NR), .ROUND_CYCLES(S_RC)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .ready(s_ready), .plain_text_in(s_plain_text_in),
    .cipher_out(s_cipher_out), .cipher_valid(s_cipher_valid), .cipher_ack(s_cipher_ack),
    .key_rd(s_key_rd), .key_addr(s_key_addr), .key_data(s_key_data), .load_text(s_load_text),
    .round_number(s_round_number), .counter(s_counter), .round_plain_text(s_round_plain_text),
    .round_key(s_round_key), .round_cipher_text(s_round_cipher_text)
  );

  // Key RAMs with one-cycle read latency; round stubbed as text XOR key.
  always @(posedge clk) if (key_rd) key_data <= key_mem[key_addr];
  always @(posedge clk) if (s_key_rd) s_key_data <= s_key_mem[s_key_addr];
  assign round_cipher_text   = round_plain_text ^ round_key;
  assign s_round_cipher_text = s_round_plain_text ^ s_round_key;

  logic [3:0] addr_q[$];
  logic [3:0] rn_q[$];
  int         dbl_load = 0;
  int         s_cnt_max = 0;
  logic       prev_load = 1'b0;

  always @(negedge clk) begin
    if (key_rd) addr_q.push_back(key_addr);
    if (load_text) rn_q.push_back(round_number);
    if (load_text && prev_load) dbl_load <= dbl_load + 1;
    prev_load <= load_text;
    if (int'(s_counter) > s_cnt_max) s_cnt_max <= int'(s_counter);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_ct(input logic [127:0] pt);
    logic [127:0] acc;
    acc = pt;
    for (int i = 0; i <= NR; i++) acc = acc ^ key_mem[i];
    return acc;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_valid(input string tag, output int lat);
    int n;
    n = 0;
    while (!cipher_valid && n < LAT + 50) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    if (!cipher_valid) check({tag, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic run_enc(input logic [127:0] pt, input int ack_delay, input string tag,
                         output logic [127:0] ct, output int lat);
    @(negedge clk);
    check({tag, "_ready"}, ready, 1);
    start = 1'b1;
    plain_text_in = pt;
    @(posedge clk); #1;
    start = 1'b0;
    plain_text_in = rnd128();
    wait_valid(tag, lat);
    ct = cipher_out;
    for (int i = 0; i < ack_delay; i++) begin
      start = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (ack_delay > 0) begin
      check({tag, "_hold_ct"}, cipher_out, ct);
      check({tag, "_hold_valid"}, cipher_valid, 1);
      check({tag, "_hold_ready"}, ready, 0);
    end
    cipher_ack = 1'b1;
    @(posedge clk); #1;
    cipher_ack = 1'b0;
    check({tag, "_valid_drop"}, cipher_valid, 0);
    check({tag, "_ready_back"}, ready, 1);
  endtask

  typedef struct {
    logic [127:0] pt;
    int           ack_delay;
    logic [127:0] exp_ct;
    int           exp_lat;
  } vec_t;

  vec_t         tbl[4];
  logic [127:0] ct, pt, exp;
  int           lat, abase, rbase, bad, n, ad;

  initial begin
    tbl[0] = '{128'h0, 0, {16{8'h0C}}, 74};
    tbl[1] = '{{16{8'hFF}}, 1, {16{8'hF3}}, 74};
    tbl[2] = '{128'h00112233445566778899AABBCCDDEEFF, 20, 128'h0C1D2E3F48596A7B8495A6B7C0D1E2F3, 74};
    tbl[3] = '{{16{8'h0C}}, 3, 128'h0, 74};

    for (int i = 0; i < 16; i++) key_mem[i] = {16{8'(i)}};
    s_key_mem[0] = rnd128();
    s_key_mem[1] = rnd128();
    for (int i = 2; i < 16; i++) s_key_mem[i] = '0;

    reset = 1'b1; start = 1'b0; cipher_ack = 1'b0; plain_text_in = '0;
    s_start = 1'b0; s_cipher_ack = 1'b0; s_plain_text_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    check("idle_ready", ready, 1);
    check("idle_valid", cipher_valid, 0);
    check("idle_load", load_text, 0);
    check("idle_key_addr", key_addr, 0);
    check("idle_key_rd", key_rd, 0);

    for (int i = 0; i < 4; i++) begin
      abase = addr_q.size();
      rbase = rn_q.size();
      run_enc(tbl[i].pt, tbl[i].ack_delay, $sformatf("tbl%0d", i), ct, lat);
      check($sformatf("tbl%0d_ct", i), ct, tbl[i].exp_ct);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      if (i == 0) begin
        bad = (addr_q.size() - abase != NR + 1) ? 1 : 0;
        for (int k = 0; k <= NR && abase + k < addr_q.size(); k++)
          if (addr_q[abase + k] != 4'(k)) bad++;
        check("key_addr_seq", bad, 0);
        bad = (rn_q.size() - rbase != NR) ? 1 : 0;
        for (int k = 0; k < NR && rbase + k < rn_q.size(); k++)
          if (rn_q[rbase + k] != 4'(k + 1)) bad++;
        check("round_number_seq", bad, 0);
      end
    end

    // Reset asserted in the middle of round 5.
    @(negedge clk);
    start = 1'b1; plain_text_in = rnd128();
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(round_number == 4'd5 && counter == 4'd2) && n < LAT) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reset_reached", (round_number == 4'd5 && counter == 4'd2), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", ready, 1);
    check("rst_valid", cipher_valid, 0);
    check("rst_load", load_text, 0);
    check("rst_round_number", round_number, 0);
    check("rst_counter", counter, 0);
    check("rst_round_key", round_key, 0);
    check("rst_round_pt", round_plain_text, 0);
    check("rst_cipher_out", cipher_out, 0);
    check("rst_key_rd", key_rd, 0);
    reset = 1'b0;
    run_enc(128'h0, 0, "post_rst", ct, lat);
    check("post_rst_ct", ct, {16{8'h0C}});
    check("post_rst_lat", lat, LAT);

    // Start held through DONE is taken on the first IDLE cycle.
    pt = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    @(negedge clk);
    start = 1'b1; plain_text_in = pt;
    @(posedge clk); #1;
    wait_valid("b2b_a", lat);
    check("b2b_a_lat", lat, LAT);
    cipher_ack = 1'b1;
    @(posedge clk); #1;
    cipher_ack = 1'b0;
    check("b2b_idle_ready", ready, 1);
    @(posedge clk); #1;
    check("b2b_accepted", ready, 0);
    start = 1'b0;
    wait_valid("b2b_b", lat);
    check("b2b_b_lat", lat, LAT);
    check("b2b_b_ct", cipher_out, pt ^ {16{8'h0C}});
    cipher_ack = 1'b1;
    @(posedge clk); #1;
    cipher_ack = 1'b0;

    // Randomized keys and plaintexts against the XOR-fold reference.
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k <= NR; k++) key_mem[k] = rnd128();
      pt = rnd128();
      ad = $urandom_range(0, 3);
      exp = model_ct(pt);
      run_enc(pt, ad, $sformatf("rnd%0d", it), ct, lat);
      check($sformatf("rnd%0d_ct", it), ct, exp);
      check($sformatf("rnd%0d_lat", it), lat, LAT);
    end

    // Single-round, single-cycle configuration.
    pt = rnd128();
    @(negedge clk);
    check("small_ready", s_ready, 1);
    s_start = 1'b1; s_plain_text_in = pt;
    @(posedge clk); #1;
    s_start = 1'b0; s_plain_text_in = rnd128();
    n = 0;
    while (!s_cipher_valid && n < S_LAT + 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("small_lat", n, S_LAT);
    check("small_ct", s_cipher_out, pt ^ s_key_mem[0] ^ s_key_mem[1]);
    s_cipher_ack = 1'b1;
    @(posedge clk); #1;
    s_cipher_ack = 1'b0;
    check("small_valid_drop", s_cipher_valid, 0);
    check("small_counter_max", (s_cnt_max <= 1), 1);

    check("double_load", dbl_load, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
